// File: rtl/bnn_load_ctrl.sv
// Serial loader for the BNN input path: strobe-edge capture, LSB-first word assembly, buffer writes, done/ack handoff.
// Optional inter-strobe timeout abort is compiled in with `define LOADER_TIMEOUT_EN.
module bnn_load_ctrl #(
  parameter int PIX_BITS    = 784,
  parameter int WGT_BITS    = 1024,
  parameter int WORD_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              sync_strb,
  input  logic              sync_p,
  input  logic              sync_w,
  input  logic              ack,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [WORD_W-1:0] pix_wdata,
  output logic              wgt_we,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic [WORD_W-1:0] wgt_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int PCW       = $clog2(PIX_BITS + 1);
  localparam int WCW       = $clog2(WGT_BITS + 1);
  localparam int BW        = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int MAX_BITS  = (PIX_BITS > WGT_BITS) ? PIX_BITS : WGT_BITS;
  localparam int MAX_WORDS = (MAX_BITS + WORD_W - 1) / WORD_W;

  if ((2 ** ADDR_W) < MAX_WORDS || TIMEOUT_CYC < 1) begin : g_param_err
    $error("bnn_load_ctrl: ADDR_W too small or TIMEOUT_CYC < 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic              strb_q, strb_d;
  logic [PCW-1:0]    pix_cnt_q, pix_cnt_d;
  logic [WCW-1:0]    wgt_cnt_q, wgt_cnt_d;
  logic [BW-1:0]     pix_bit_q, pix_bit_d, wgt_bit_q, wgt_bit_d;
  logic [WORD_W-1:0] pix_sr_q, pix_sr_d, wgt_sr_q, wgt_sr_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d, wgt_addr_q, wgt_addr_d;
  logic              pix_we_q, pix_we_d, wgt_we_q, wgt_we_d;
  logic [WORD_W-1:0] pix_wdata_q, pix_wdata_d, wgt_wdata_q, wgt_wdata_d;
  logic              busy_q, busy_d, load_done_q, load_done_d;
  logic              overrun_q, overrun_d;
  logic [WORD_W-1:0] pix_word, wgt_word;
  logic              strb_edge, pix_full, wgt_full, pix_last, wgt_last;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_err_q, timeout_err_d;
`endif

  assign strb_edge = sync_strb & ~strb_q;
  assign pix_full  = (pix_cnt_q == PCW'(PIX_BITS));
  assign wgt_full  = (wgt_cnt_q == WCW'(WGT_BITS));
  // A word closes on its top bit or on the lane's final bit (short last word).
  assign pix_last  = (pix_bit_q == BW'(WORD_W - 1)) || (pix_cnt_q == PCW'(PIX_BITS - 1));
  assign wgt_last  = (wgt_bit_q == BW'(WORD_W - 1)) || (wgt_cnt_q == WCW'(WGT_BITS - 1));

  always_comb begin
    state_d     = state_q;
    strb_d      = sync_strb;
    pix_cnt_d   = pix_cnt_q;
    wgt_cnt_d   = wgt_cnt_q;
    pix_bit_d   = pix_bit_q;
    wgt_bit_d   = wgt_bit_q;
    pix_sr_d    = pix_sr_q;
    wgt_sr_d    = wgt_sr_q;
    // The address presented with a write advances once that write has been seen.
    pix_addr_d  = pix_we_q ? pix_addr_q + ADDR_W'(1) : pix_addr_q;
    wgt_addr_d  = wgt_we_q ? wgt_addr_q + ADDR_W'(1) : wgt_addr_q;
    pix_we_d    = 1'b0;
    wgt_we_d    = 1'b0;
    pix_wdata_d = pix_wdata_q;
    wgt_wdata_d = wgt_wdata_q;
    overrun_d   = overrun_q;
    pix_word    = pix_sr_q;
    wgt_word    = wgt_sr_q;
`ifdef LOADER_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          pix_cnt_d  = '0;
          wgt_cnt_d  = '0;
          pix_bit_d  = '0;
          wgt_bit_d  = '0;
          pix_sr_d   = '0;
          wgt_sr_d   = '0;
          pix_addr_d = '0;
          wgt_addr_d = '0;
          overrun_d  = 1'b0;
`ifdef LOADER_TIMEOUT_EN
          tmo_cnt_d     = '0;
          timeout_err_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (pix_full && wgt_full) state_d = DONE;
        if (strb_edge) begin
          if (pix_full && wgt_full) overrun_d = 1'b1;
          if (!pix_full) begin
            pix_word[pix_bit_q] = sync_p;
            pix_cnt_d = pix_cnt_q + PCW'(1);
            if (pix_last) begin
              pix_we_d    = 1'b1;
              pix_wdata_d = pix_word;
              pix_sr_d    = '0;
              pix_bit_d   = '0;
            end else begin
              pix_sr_d  = pix_word;
              pix_bit_d = pix_bit_q + BW'(1);
            end
          end
          if (!wgt_full) begin
            wgt_word[wgt_bit_q] = sync_w;
            wgt_cnt_d = wgt_cnt_q + WCW'(1);
            if (wgt_last) begin
              wgt_we_d    = 1'b1;
              wgt_wdata_d = wgt_word;
              wgt_sr_d    = '0;
              wgt_bit_d   = '0;
            end else begin
              wgt_sr_d  = wgt_word;
              wgt_bit_d = wgt_bit_q + BW'(1);
            end
          end
        end
`ifdef LOADER_TIMEOUT_EN
        if (strb_edge) begin
          tmo_cnt_d = '0;
        end else if (!(pix_full && wgt_full) && tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
          pix_sr_d      = '0;
          wgt_sr_d      = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      DONE: begin
        if (strb_edge) overrun_d = 1'b1;
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d == LOAD);
    load_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      strb_q      <= 1'b0;
      pix_cnt_q   <= '0;
      wgt_cnt_q   <= '0;
      pix_bit_q   <= '0;
      wgt_bit_q   <= '0;
      pix_sr_q    <= '0;
      wgt_sr_q    <= '0;
      pix_addr_q  <= '0;
      wgt_addr_q  <= '0;
      pix_we_q    <= 1'b0;
      wgt_we_q    <= 1'b0;
      pix_wdata_q <= '0;
      wgt_wdata_q <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      strb_q      <= strb_d;
      pix_cnt_q   <= pix_cnt_d;
      wgt_cnt_q   <= wgt_cnt_d;
      pix_bit_q   <= pix_bit_d;
      wgt_bit_q   <= wgt_bit_d;
      pix_sr_q    <= pix_sr_d;
      wgt_sr_q    <= wgt_sr_d;
      pix_addr_q  <= pix_addr_d;
      wgt_addr_q  <= wgt_addr_d;
      pix_we_q    <= pix_we_d;
      wgt_we_q    <= wgt_we_d;
      pix_wdata_q <= pix_wdata_d;
      wgt_wdata_q <= wgt_wdata_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign pix_we    = pix_we_q;
  assign pix_addr  = pix_addr_q;
  assign pix_wdata = pix_wdata_q;
  assign wgt_we    = wgt_we_q;
  assign wgt_addr  = wgt_addr_q;
  assign wgt_wdata = wgt_wdata_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_bnn_load_ctrl.sv
// Bench for bnn_load_ctrl: a default instance and a small one (12 pixel / 16 weight bits, timeout 100)
// share one stimulus stream; a bit-level model queues every expected buffer write.
module tb_bnn_load_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, sync_strb = 1'b0;
  logic sync_p = 1'b0, sync_w = 1'b0, ack = 1'b0;

  logic       a_pix_we, a_wgt_we, a_busy, a_load_done, a_overrun, a_timeout_err;
  logic [6:0] a_pix_addr, a_wgt_addr;
  logic [7:0] a_pix_wdata, a_wgt_wdata;
  logic       s_pix_we, s_wgt_we, s_busy, s_load_done, s_overrun, s_timeout_err;
  logic [6:0] s_pix_addr, s_wgt_addr;
  logic [7:0] s_pix_wdata, s_wgt_wdata;

  bnn_load_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sync_strb(sync_strb), .sync_p(sync_p),
    .sync_w(sync_w), .ack(ack), .pix_we(a_pix_we), .pix_addr(a_pix_addr), .pix_wdata(a_pix_wdata),
    .wgt_we(a_wgt_we), .wgt_addr(a_wgt_addr), .wgt_wdata(a_wgt_wdata), .busy(a_busy),
    .load_done(a_load_done), .overrun(a_overrun), .timeout_err(a_timeout_err));

  bnn_load_ctrl #(.PIX_BITS(12), .WGT_BITS(16), .TIMEOUT_CYC(100)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start), .sync_strb(sync_strb), .sync_p(sync_p),
    .sync_w(sync_w), .ack(ack), .pix_we(s_pix_we), .pix_addr(s_pix_addr), .pix_wdata(s_pix_wdata),
    .wgt_we(s_wgt_we), .wgt_addr(s_wgt_addr), .wgt_wdata(s_wgt_wdata), .busy(s_busy),
    .load_done(s_load_done), .overrun(s_overrun), .timeout_err(s_timeout_err));

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: {addr[6:0], data[7:0]} per lane (0 a_pix, 1 a_wgt, 2 s_pix, 3 s_wgt)
  logic [14:0] q0[$], q1[$], q2[$], q3[$];
  int          m_cnt[4], m_addr[4];
  logic [7:0]  m_sr[4];
  bit          act[2];
  int          wr_cnt[4];
  int          last_aw_cyc = 0, a_done_cyc = 0, s_to_cyc = 0, last_rise_cyc = 0;
  logic        a_done_prev = 1'b0, s_to_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lim(input int i);
    case (i)
      0: return 784;
      1: return 1024;
      2: return 12;
      default: return 16;
    endcase
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [14:0] qpop(input int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  task automatic qpush(input int i, input logic [14:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  task automatic lane_bit(input int i, input bit b);
    int bi;
    if (act[i / 2] && m_cnt[i] < lim(i)) begin
      bi = m_cnt[i] % 8;
      m_sr[i][bi] = b;
      m_cnt[i]++;
      if (bi == 7 || m_cnt[i] == lim(i)) begin
        qpush(i, {7'(m_addr[i]), m_sr[i]});
        m_addr[i]++;
        m_sr[i] = 8'h00;
      end
    end
  endtask

  task automatic lane_mon(input int i, input string tag, input logic [6:0] addr, input logic [7:0] data);
    wr_cnt[i]++;
    chk({tag, "_pending"}, 32'(qsize(i) > 0), 32'd1);
    if (qsize(i) > 0) chk(tag, {17'd0, addr, data}, {17'd0, qpop(i)});
  endtask

  always @(negedge clk) begin
    if (a_pix_we) lane_mon(0, "a_pix_wr", a_pix_addr, a_pix_wdata);
    if (a_wgt_we) begin
      lane_mon(1, "a_wgt_wr", a_wgt_addr, a_wgt_wdata);
      last_aw_cyc = cyc;
    end
    if (s_pix_we) lane_mon(2, "s_pix_wr", s_pix_addr, s_pix_wdata);
    if (s_wgt_we) lane_mon(3, "s_wgt_wr", s_wgt_addr, s_wgt_wdata);
    if (a_load_done && !a_done_prev) a_done_cyc = cyc;
    if (s_timeout_err && !s_to_prev) s_to_cyc = cyc;
    a_done_prev = a_load_done;
    s_to_prev   = s_timeout_err;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk) #1;
  endtask

  task automatic pulse_start();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_addr[i] = 0; m_sr[i] = 8'h00;
    end
    act[0] = 1'b1; act[1] = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic strobe(input bit p, input bit w);
    sync_p = p; sync_w = w;
    tick(1);
    sync_strb = 1'b1;
    last_rise_cyc = cyc;
    lane_bit(0, p); lane_bit(1, w); lane_bit(2, p); lane_bit(3, w);
    tick(2);
    sync_strb = 1'b0;
    tick(2);
  endtask

  function automatic bit pat(input logic [7:0] v, input int i);
    logic [7:0] t;
    t = v;
    return t[i % 8];
  endfunction

  initial begin
    // Reset state
    tick(2);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_load_done, 0);
    chk("rst_pix_we", a_pix_we, 0);
    chk("rst_wgt_addr", a_wgt_addr, 0);
    chk("rst_overrun", a_overrun, 0);
    chk("rst_timeout", s_timeout_err, 0);
    reset_n = 1'b1;
    tick(2);

    // Full load: pixel 0xA5, weight 0x3C, LSB-first
    chk("busy_before_start", a_busy, 0);
    pulse_start();
    chk("busy_after_start", a_busy, 1);
    for (int i = 0; i < 1024; i++) strobe(pat(8'hA5, i), pat(8'h3C, i));
    tick(3);
    chk("full_q_empty", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 0);
    chk("full_pix_writes", wr_cnt[0], 98);
    chk("full_wgt_writes", wr_cnt[1], 128);
    chk("full_load_done", a_load_done, 1);
    chk("full_busy", a_busy, 0);
    chk("done_after_last_we", 32'(a_done_cyc - last_aw_cyc), 1);
    chk("full_no_overrun", a_overrun, 0);
    chk("small_pix_writes", wr_cnt[2], 2);
    chk("small_done", s_load_done, 1);
    chk("small_overrun", s_overrun, 1);

    // Extra strobe in DONE
    strobe(1'b1, 1'b1);
    chk("done_edge_overrun", a_overrun, 1);
    chk("done_edge_no_pix_wr", wr_cnt[0], 98);
    chk("done_edge_no_wgt_wr", wr_cnt[1], 128);
    chk("done_held", a_load_done, 1);

    // ack and start together: ack wins, start dropped
    act[0] = 1'b0; act[1] = 1'b0;
    ack = 1'b1; start = 1'b1;
    tick(1);
    ack = 1'b0; start = 1'b0;
    chk("ack_done_low", a_load_done, 0);
    chk("ack_busy_low", a_busy, 0);
    tick(1);
    chk("ack_start_dropped", a_busy, 0);

    // Strobe held high across start, then 16 bits: pixel all ones, weight 0x55
    sync_strb = 1'b1;
    tick(3);
    pulse_start();
    chk("start_clears_overrun", a_overrun, 0);
    chk("start_busy_high_strb", a_busy, 1);
    tick(2);
    sync_strb = 1'b0;
    tick(2);
    for (int i = 0; i < 16; i++) strobe(1'b1, (i % 2) == 0);
    tick(3);
    chk("short_q_empty", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 0);
    chk("short_small_pix_writes", wr_cnt[2], 4);
    chk("short_small_wgt_writes", wr_cnt[3], 4);
    chk("short_small_done", s_load_done, 1);
    chk("short_big_pix_writes", wr_cnt[0], 100);
    chk("short_big_busy", a_busy, 1);

    // Reset mid-load with a partial word pending
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
    @(posedge clk) #2;
    reset_n = 1'b0;
    act[0] = 1'b0; act[1] = 1'b0;
    #1;
    chk("midrst_busy", a_busy, 0);
    chk("midrst_pix_addr", a_pix_addr, 0);
    chk("midrst_pix_wdata", a_pix_wdata, 0);
    chk("midrst_wgt_addr", a_wgt_addr, 0);
    chk("midrst_small_done", s_load_done, 0);
    chk("midrst_small_overrun", s_overrun, 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    for (int i = 0; i < 10; i++) strobe(1'b1, 1'b1);
    chk("postrst_no_pix_wr", wr_cnt[0], 100);
    chk("postrst_no_wgt_wr", wr_cnt[1], 130);
    chk("postrst_idle", a_busy, 0);

`ifdef LOADER_TIMEOUT_EN
    // Five edges then silence on the small instance (timeout 100)
    begin
      int n;
      int edge_cyc;
      pulse_start();
      for (int i = 0; i < 5; i++) strobe(1'b1, 1'b1);
      edge_cyc = last_rise_cyc + 1;
      n = 0;
      while (!s_timeout_err && n < 300) begin
        tick(1);
        n++;
      end
      chk("tmo_flag", s_timeout_err, 1);
      chk("tmo_latency", 32'(s_to_cyc - edge_cyc), 100);
      chk("tmo_busy", s_busy, 0);
      chk("tmo_no_done", s_load_done, 0);
      chk("tmo_no_pix_wr", wr_cnt[2], 4);
      act[0] = 1'b0; act[1] = 1'b0;
      tick(5);
      chk("tmo_sticky", s_timeout_err, 1);
      pulse_start();
      chk("tmo_cleared_by_start", s_timeout_err, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
